// File: rtl/led_pattern_pkg.sv
// Shared types and constants for the LED pattern generator.
// Phase encoding, per-phase step limits and the pattern ROMs live here.
package led_pattern_pkg;

    typedef enum logic [1:0] {
        COUNT = 2'd0,
        SCAN  = 2'd1,
        FLASH = 2'd2
    } phase_t;

    localparam logic [3:0] COUNT_LAST = 4'd15;
    localparam logic [3:0] SCAN_LAST  = 4'd5;
    localparam logic [3:0] FLASH_LAST = 4'd3;

    localparam logic [0:5][3:0] SCAN_ROM = {
        4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010
    };
    localparam logic [0:3][3:0] FLASH_ROM = {
        4'b1111, 4'b0000, 4'b1111, 4'b0000
    };

    // Out-of-range steps and illegal phases show dark rather than garbage.
    function automatic logic [3:0] pattern(phase_t phase, logic [3:0] step);
        logic [3:0] pat;
        pat = 4'b0000;
        case (phase)
            COUNT: pat = step;
            SCAN:  if (step <= SCAN_LAST) pat = SCAN_ROM[step[2:0]];
            FLASH: if (step <= FLASH_LAST) pat = FLASH_ROM[step[1:0]];
            default: pat = 4'b0000;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/led_pattern_if.sv
// LED pin bundle: the top drives it through the master modport.
interface led_pattern_if;
    logic [3:0] led;

    modport master (output led);
    modport slave  (input led);
endinterface

// File: rtl/led_prescaler.sv
// Step-tick prescaler: one-cycle tick every TICK_DIV clocks.
module led_prescaler #(
    parameter int unsigned TICK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] div_cnt_q;
    logic [CNT_W-1:0] div_cnt_d;

    always_comb begin
        tick      = (div_cnt_q == CNT_LAST);
        div_cnt_d = tick ? '0 : div_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/led_pattern_top.sv
// Board-level LED pattern generator: count / scan / flash sequencer
// stepped by a prescaler, gated by a global PWM brightness mask.
module led_pattern_top
    import led_pattern_pkg::*;
#(
    parameter int unsigned TICK_DIV = 25_000_000,
    parameter int unsigned PWM_BITS = 4,
    parameter int unsigned DUTY     = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    led_pattern_if.master bus
);

    // One extra bit so that DUTY = 2**PWM_BITS means always on.
    localparam logic [PWM_BITS:0] DUTY_W = (PWM_BITS + 1)'(DUTY);

    logic                tick;
    phase_t              phase_q;
    phase_t              phase_d;
    logic [3:0]          step_q;
    logic [3:0]          step_d;
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic                pwm_on;
    logic [3:0]          led_q;

    led_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    always_comb begin
        phase_d = phase_q;
        step_d  = step_q;
        case (phase_q)
            COUNT: begin
                if (tick) begin
                    if (step_q >= COUNT_LAST) begin
                        phase_d = SCAN;
                        step_d  = '0;
                    end else begin
                        step_d = step_q + 4'd1;
                    end
                end
            end
            SCAN: begin
                if (tick) begin
                    if (step_q >= SCAN_LAST) begin
                        phase_d = FLASH;
                        step_d  = '0;
                    end else begin
                        step_d = step_q + 4'd1;
                    end
                end
            end
            FLASH: begin
                if (tick) begin
                    if (step_q >= FLASH_LAST) begin
                        phase_d = COUNT;
                        step_d  = '0;
                    end else begin
                        step_d = step_q + 4'd1;
                    end
                end
            end
            // Illegal encoding recovers without waiting for a tick.
            default: begin
                phase_d = COUNT;
                step_d  = '0;
            end
        endcase
    end

    always_comb begin
        pwm_on = ({1'b0, pwm_cnt_q} < DUTY_W);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q   <= COUNT;
            step_q    <= '0;
            pwm_cnt_q <= '0;
            led_q     <= '0;
        end else begin
            phase_q   <= phase_d;
            step_q    <= step_d;
            pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
            led_q     <= pattern(phase_q, step_q) & {4{pwm_on}};
        end
    end

    assign bus.led = led_q;

endmodule

// File: tb/tb_led_pattern_top.sv
// Bench for led_pattern_top: four instances (full duty, quarter duty, dark,
// default parameters) share clock and reset and are checked edge by edge.
module tb_led_pattern_top;

    typedef struct {
        string      tag;
        logic [3:0] led;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #10 clk = ~clk;

    led_pattern_if if_a ();
    led_pattern_if if_b ();
    led_pattern_if if_c ();
    led_pattern_if if_d ();

    led_pattern_top #(.TICK_DIV(4), .PWM_BITS(4), .DUTY(16)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_a)
    );
    led_pattern_top #(.TICK_DIV(4), .PWM_BITS(4), .DUTY(4)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_b)
    );
    led_pattern_top #(.TICK_DIV(4), .PWM_BITS(4), .DUTY(0)) dut_c (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_c)
    );
    led_pattern_top dut_d (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_d)
    );

    vec_t seq_tab [26];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic edge_tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int         idx;
        int         lit_b;
        int         bad;
        logic [3:0] exp;

        for (int k = 0; k < 16; k++) begin
            seq_tab[k].tag = $sformatf("cnt%0d", k);
            seq_tab[k].led = 4'(k);
        end
        seq_tab[16] = '{"scan0", 4'b0001};
        seq_tab[17] = '{"scan1", 4'b0010};
        seq_tab[18] = '{"scan2", 4'b0100};
        seq_tab[19] = '{"scan3", 4'b1000};
        seq_tab[20] = '{"scan4", 4'b0100};
        seq_tab[21] = '{"scan5", 4'b0010};
        seq_tab[22] = '{"flash0", 4'b1111};
        seq_tab[23] = '{"flash1", 4'b0000};
        seq_tab[24] = '{"flash2", 4'b1111};
        seq_tab[25] = '{"flash3", 4'b0000};

        rst_n = 1'b0;
        repeat (3) begin
            edge_tick();
            chk("rst_a", if_a.led, 4'b0000);
            chk("rst_b", if_b.led, 4'b0000);
            chk("rst_c", if_c.led, 4'b0000);
            chk("rst_dflt", if_d.led, 4'b0000);
        end
        rst_n = 1'b1;

        // Step k is visible on edges 4k+1..4k+4 after release; B is lit only
        // where the PWM count sampled by that edge, (n-1) mod 16, is below 4.
        lit_b = 0;
        for (int n = 1; n <= 182; n++) begin
            edge_tick();
            idx = ((n - 1) / 4) % 26;
            exp = seq_tab[idx].led;
            chk({"a_", seq_tab[idx].tag}, if_a.led, exp);
            chk({"b_", seq_tab[idx].tag}, if_b.led, (((n - 1) % 16) < 4) ? exp : 4'b0000);
            chk("c_dark", if_c.led, 4'b0000);
            chk("dflt_dark", if_d.led, 4'b0000);
            if (n >= 89 && n <= 104 && if_b.led == 4'b1111) lit_b++;
        end
        chk_int("b_flash_lit_of_16", lit_b, 4);

        // Edge 182 showed SCAN step 3; reset lands on the next edge.
        rst_n = 1'b0;
        edge_tick();
        chk("midrst_a", if_a.led, 4'b0000);
        chk("midrst_b", if_b.led, 4'b0000);
        rst_n = 1'b1;
        for (int r = 1; r <= 5; r++) begin
            edge_tick();
            chk($sformatf("post_rst_a_e%0d", r), if_a.led, (r == 5) ? 4'b0001 : 4'b0000);
            chk($sformatf("post_rst_b_e%0d", r), if_b.led, 4'b0000);
            chk($sformatf("post_rst_c_e%0d", r), if_c.led, 4'b0000);
        end

        // 1 ms at 50 MHz: the default prescaler never ticks in this window.
        bad = 0;
        repeat (50000) begin
            edge_tick();
            if (if_d.led !== 4'b0000) bad++;
        end
        chk_int("dflt_1ms_dark", bad, 0);
        chk("dflt_final", if_d.led, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_pattern_top.md
Name: led_pattern_top

Overview:
- Free-running 4-LED pattern generator for the board top level; only inputs are the 50 MHz board clock and a reset.
- A prescaler creates a slow step tick that drives a three-phase sequencer: binary count, then scanner, then flash.
- A global PWM mask sets LED brightness.
- Outputs are registered and drive the LED pins directly.

Parameters:
- TICK_DIV, 25_000_000, clock cycles per sequencer step (0.5 s at 50 MHz); minimum 2; benches override with a small value.
- PWM_BITS, 4, width of the brightness PWM counter.
- DUTY, 16, PWM on-cycles per PWM period, range 0..2**PWM_BITS; 16 means always on, 0 means LEDs always off.

Ports:
- clk  input  1  board clock, 50 MHz; all logic on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- led  output  4  LED drive, active-high, registered.

Behaviour:
- Reset: one clock; reset is synchronous and active-low. While rst_n=0 at a rising edge:
  - div_cnt=0, pwm_cnt=0
  - phase=COUNT, step=0
  - led=4'b0000
- Reset asserted mid-sequence returns to this state at the next edge, regardless of phase or step.
- Prescaler:
  - div_cnt counts 0..TICK_DIV-1 and wraps to 0.
  - tick=1 for exactly one cycle, when div_cnt==TICK_DIV-1.
- Sequencer (phase, step) advances only on tick edges.
- Phase COUNT:
  - step 0..15; pattern=step[3:0].
  - At step 15 with tick, go to SCAN, step 0.
- Phase SCAN:
  - step 0..5; pattern sequence 0001, 0010, 0100, 1000, 0100, 0010.
  - At step 5 with tick, go to FLASH, step 0.
- Phase FLASH:
  - step 0..3; pattern 1111, 0000, 1111, 0000.
  - At step 3 with tick, go to COUNT, step 0.
- Full cycle is 26 ticks (26*TICK_DIV clocks). The sequence wraps indefinitely.
- An illegal phase encoding recovers to COUNT, step 0, on the next edge.
- PWM:
  - pwm_cnt is free-running modulo 2**PWM_BITS and starts at 0 after reset.
  - pwm_on = (pwm_cnt < DUTY), compared with width PWM_BITS+1 so that DUTY=16 is legal.
- Output: every edge out of reset, led <= pattern(phase,step) & {4{pwm_on}}.
  - This is a one-cycle registered lag behind the phase/step registers.
- Timing with DUTY=16:
  - First edge after reset release: led=0000 (COUNT step 0).
  - led becomes 0001 at the edge one cycle after tick edge #1, i.e. TICK_DIV+1 edges after release.
- No other inputs, no handshakes. Outputs never show X after the first reset edge.

Decomposition:
- Package led_pattern_pkg:
  - phase enum (COUNT, SCAN, FLASH, 2-bit).
  - Step-limit constants COUNT_LAST=15, SCAN_LAST=5, FLASH_LAST=3.
  - SCAN and FLASH pattern ROM constants.
- One natural sub-module: led_prescaler (parameter TICK_DIV; ports clk, rst_n, tick).
- Sequencer, PWM and output register stay in the top.

Test Plan:
- Reset, TICK_DIV=4, DUTY=16: hold rst_n=0 for 3 edges -> led=0000. After release, led stays 0000 for 4 edges, then reads 0001 at edge 5 and 0010 at edge 9.
- Full sequence, TICK_DIV=4: sample led once per step for 26 ticks -> 0000..1111 binary, then 0001,0010,0100,1000,0100,0010, then 1111,0000,1111,0000, then 0000 again (wrap to COUNT).
- Mid-run reset: assert rst_n=0 for 1 edge during SCAN step 3 -> next edge led=0000. Sequence restarts at COUNT step 0 and reaches 0001 TICK_DIV+1 edges after release.
- PWM duty, TICK_DIV=4, DUTY=4, during FLASH 1111 -> led=1111 for 4 of every 16 consecutive cycles, 0000 for the other 12.
- DUTY=0 -> led=0000 throughout a full 26-tick cycle.
- Default parameters with a 50 MHz clock for 1 ms -> led remains 0000 and is never X after reset; div_cnt does not reach TICK_DIV-1.
